bpb_resolve_queue: RTL
======================

# bpb_resolve_queue

In-order tracker of in-flight branch predictions between fetch and branch resolution. It records every prediction issued at fetch and pops the oldest entry when the pipeline resolves that branch. It drives the pattern history table's update port with the actual outcome and raises a registered mispredict/redirect, squashing all younger predictions. It also keeps saturating accuracy counters for performance monitoring.

## Interface
- `INDEX_WIDTH`, default `` `BPB_T `` (from `bpb.svh`): width of the PHT index carried per entry.
- `DEPTH`, default 4: queue entries; power of two, ≥2.
- `ADDR_WIDTH`, default 32: redirect address width.
- `CNT_WIDTH`, default 16: statistics counter width.

Ports:
- `clk_i`, in, 1: clock; all state changes on rising edge.
- `rst_ni`, in, 1: reset; asynchronous, active-low.
- `en_i`, in, 1: pipeline enable. When 0, no state changes and pulse outputs are 0 next cycle.
- `push_i`, in, 1: fetch issued a branch prediction this cycle.
- `push_index_i`, in, INDEX_WIDTH: PHT index used for the prediction.
- `push_taken_i`, in, 1: predicted direction.
- `push_alt_pc_i`, in, ADDR_WIDTH: address to fetch if the prediction proves wrong.
- `full_o`, out, 1: count == DEPTH (combinational from state).
- `count_o`, out, $clog2(DEPTH)+1: occupied entries.
- `resolve_i`, in, 1: oldest in-flight branch resolved this cycle.
- `resolve_taken_i`, in, 1: actual direction.
- `update_en_o`, out, 1: PHT update strobe (registered pulse).
- `update_index_o`, out, INDEX_WIDTH: index to update.
- `last_taken_o`, out, 1: actual outcome for the PHT.
- `mispredict_o`, out, 1: registered one-cycle flush/redirect pulse.
- `redirect_pc_o`, out, ADDR_WIDTH: valid when `mispredict_o` is 1.
- `branch_cnt_o`, out, CNT_WIDTH: resolved branches, saturating.
- `miss_cnt_o`, out, CNT_WIDTH: mispredicted branches, saturating.
- `err_o`, out, 1: sticky protocol error (push while full, or resolve while empty).

## Operation
- **Storage.** Circular FIFO of {index, taken, alt_pc} with head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. A separate count register distinguishes full from empty.
- **Push.** A push is accepted iff `en_i & push_i & ~full_o & ~flush`. The entry is written at tail, and tail increments.
- **Resolve.** A resolve is accepted iff `en_i & resolve_i & count != 0`. The head entry is read and popped.
- **Result registers.** On each accepted resolve, next cycle:
  - `update_en_o` = 1
  - `update_index_o` = head.index
  - `last_taken_o` = `resolve_taken_i`
  - `branch_cnt_o` += 1
- **Mispredict.** `flush` = accepted resolve & (`resolve_taken_i` != head.taken). On flush:
  - next cycle `mispredict_o` = 1, `redirect_pc_o` = head.alt_pc, `miss_cnt_o` += 1;
  - the whole queue is cleared: head = tail = 0, count = 0;
  - a push in the same cycle is dropped as wrong-path, and this is not an error.
- **Push and resolve together, no flush.** Both are performed; count is unchanged; an empty queue cannot be resolved.
- **Counters.** Both saturate at 2^CNT_WIDTH−1 and hold.
- **Errors.** `err_o` is set on `en_i & push_i & full_o & ~flush` or on `en_i & resolve_i & count == 0`. The offending request is ignored. `err_o` clears only on reset.
- **PHT update.** The PHT update is sent even on mispredicts, so the PHT trains on every resolved branch.

## Timing
- **Reset (asynchronous, `rst_ni` = 0).** All outputs 0: `full_o`, `count_o`, `update_en_o`, `update_index_o`, `last_taken_o`, `mispredict_o`, `redirect_pc_o`, both counters, `err_o`. Pointers are 0. Entry contents are don't-care.
- **Reset mid-operation.** All in-flight entries and any pending pulse are lost immediately. No update or redirect is emitted after reset deasserts.
- **Latency.**
  - Resolve at cycle N → `update_en_o` / `mispredict_o` high for exactly cycle N+1.
  - Push at cycle N → `count_o` / `full_o` reflect it in cycle N+1.
  - A push in cycle N can be resolved in cycle N+1 at the earliest.
- **`en_i` = 0.** Queue, pointers, counters and `err_o` hold. `update_en_o` and `mispredict_o` are 0 in the next cycle. Data outputs hold their last values.
- **Back-to-back resolves.** One resolve per cycle is supported, each giving a one-cycle update pulse in the following cycle.

## Test plan
- **Fill and drain.** Reset, then push 4 entries (index 1..4, taken=1); `full_o`=1, `count_o`=4. A 5th push sets `err_o`=1 and `count_o` stays 4. Resolve ×4 with taken=1 → `update_index_o` = 1,2,3,4 on consecutive cycles, `mispredict_o` never 1, `branch_cnt_o`=4.
- **Mispredict flush.** Push A (index 5, taken=0, alt_pc 0x100), then push B and C. Resolve with taken=1 → next cycle:
  - `mispredict_o`=1, `redirect_pc_o`=0x100;
  - `update_index_o`=5, `last_taken_o`=1;
  - `count_o`=0, `miss_cnt_o`=1.
  A push concurrent with that resolve is dropped and `err_o` stays 0.
- **Simultaneous push/resolve.** With count=2 and a correct resolve plus a push in the same cycle, `count_o` stays 2. Run 8 more such cycles to force pointer wrap; FIFO order is preserved.
- **Stall.** With count=2, hold `en_i`=0 while driving resolve and push for 3 cycles: no pulses, count stays 2. Release → normal pop.
- **Reset mid-flight and empty resolve.** Assert `rst_ni`=0 asynchronously between edges with 3 entries: outputs are 0 immediately. After release, a resolve sets `err_o`=1 with no `update_en_o`.
- **Saturation.** With CNT_WIDTH=4, 17 mispredicted resolves → `branch_cnt_o`=`miss_cnt_o`=15.

Source files
------------

// File: rtl/bpb_resolve_queue_if.sv
// bpb_resolve_queue_if: fetch push, resolve, PHT update and redirect signals of the branch resolve queue.
`ifndef BPB_T
`define BPB_T 8
`endif
interface bpb_resolve_queue_if #(
    parameter int INDEX_WIDTH = `BPB_T,
    parameter int DEPTH       = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int CNT_WIDTH   = 16
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic                   push_i;
    logic [INDEX_WIDTH-1:0] push_index_i;
    logic                   push_taken_i;
    logic [ADDR_WIDTH-1:0]  push_alt_pc_i;
    logic                   full_o;
    logic [CW-1:0]          count_o;
    logic                   resolve_i;
    logic                   resolve_taken_i;
    logic                   update_en_o;
    logic [INDEX_WIDTH-1:0] update_index_o;
    logic                   last_taken_o;
    logic                   mispredict_o;
    logic [ADDR_WIDTH-1:0]  redirect_pc_o;
    logic [CNT_WIDTH-1:0]   branch_cnt_o;
    logic [CNT_WIDTH-1:0]   miss_cnt_o;
    logic                   err_o;
    modport master (
        output push_i, push_index_i, push_taken_i, push_alt_pc_i, resolve_i, resolve_taken_i,
        input  full_o, count_o, update_en_o, update_index_o, last_taken_o, mispredict_o,
               redirect_pc_o, branch_cnt_o, miss_cnt_o, err_o
    );
    modport slave (
        input  push_i, push_index_i, push_taken_i, push_alt_pc_i, resolve_i, resolve_taken_i,
        output full_o, count_o, update_en_o, update_index_o, last_taken_o, mispredict_o,
               redirect_pc_o, branch_cnt_o, miss_cnt_o, err_o
    );
endinterface

// File: rtl/bpb_resolve_queue.sv
// bpb_resolve_queue: in-order queue of in-flight branch predictions; trains the PHT and flushes on mispredict.
`ifndef BPB_T
`define BPB_T 8
`endif
module bpb_resolve_queue #(
    parameter int INDEX_WIDTH = `BPB_T,
    parameter int DEPTH       = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int CNT_WIDTH   = 16
) (
    input logic clk_i,
    input logic rst_ni,
    input logic en_i,
    bpb_resolve_queue_if.slave q
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [INDEX_WIDTH-1:0] idx_mem [DEPTH];
    logic                   tkn_mem [DEPTH];
    logic [ADDR_WIDTH-1:0]  pc_mem  [DEPTH];
    logic [PW-1:0]          head, tail;
    logic [CW-1:0]          count;
    logic                   full, empty, do_res, flush, do_push;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_res  = en_i & q.resolve_i & ~empty;
    assign flush   = do_res & (q.resolve_taken_i != tkn_mem[head]);
    // A push racing a flush is wrong-path, so it is silently dropped.
    assign do_push = en_i & q.push_i & ~full & ~flush;
    assign q.full_o  = full;
    assign q.count_o = count;
    always_ff @(posedge clk_i)
        if (do_push) begin
            idx_mem[tail] <= q.push_index_i;
            tkn_mem[tail] <= q.push_taken_i;
            pc_mem[tail]  <= q.push_alt_pc_i;
        end
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            q.update_en_o    <= 1'b0;
            q.update_index_o <= '0;
            q.last_taken_o   <= 1'b0;
            q.mispredict_o   <= 1'b0;
            q.redirect_pc_o  <= '0;
            q.branch_cnt_o   <= '0;
            q.miss_cnt_o     <= '0;
            q.err_o          <= 1'b0;
        end else begin
            head  <= flush ? '0 : head + PW'(do_res);
            tail  <= flush ? '0 : tail + PW'(do_push);
            count <= flush ? '0 : count + CW'(do_push) - CW'(do_res);
            q.update_en_o  <= do_res;
            q.mispredict_o <= flush;
            q.err_o <= q.err_o | (en_i & q.push_i & full & ~flush) | (en_i & q.resolve_i & empty);
            if (do_res) begin
                q.update_index_o <= idx_mem[head];
                q.last_taken_o   <= q.resolve_taken_i;
                if (~&q.branch_cnt_o) q.branch_cnt_o <= q.branch_cnt_o + 1'b1;
            end
            if (flush) begin
                q.redirect_pc_o <= pc_mem[head];
                if (~&q.miss_cnt_o) q.miss_cnt_o <= q.miss_cnt_o + 1'b1;
            end
        end
endmodule
